mem_interface: RTL and testbench

Memory-side stage between the datapath's MAR/MDR and a synchronous single-port RAM. It accepts one read or write request at a time from the control unit and inserts a programmable number of wait states. It drives the RAM, registers read data onto `Mdatain` for the MDR, and pulses `mem_done` when the transaction completes. All state changes occur on the rising edge of `clock`.

---
 rtl/mem_interface.sv | 125 ++++++++++++
 tb/tb_mem_interface.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// Memory-side stage between MAR/MDR and a synchronous single-port RAM.
// Sequences one read or write at a time with programmable wait states before the RAM strobe.
module mem_interface #(
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  read,
   input  logic                  write,
   input  logic [31:0]           MAR_in,
   input  logic [31:0]           MDR_in,
   output logic [31:0]           Mdatain,
   output logic                  mem_done,
   output logic                  busy,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   output logic                  ram_re,
   output logic                  ram_we,
   input  logic [31:0]           ram_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ISSUE,
      S_CAPTURE,
      S_DONE
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
   localparam logic       WAIT_EN   = (WAIT_STATES > 0);

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           mdat_q, mdat_d;
   logic                  is_write_q, is_write_d;
   logic                  err_q, err_d;
   logic                  accept;

   // Only the low ADDR_WIDTH bits of the MAR address the RAM.
   generate
      if (ADDR_WIDTH < 32) begin : g_mar_upper
         logic mar_upper_unused;
         assign mar_upper_unused = ^MAR_in[31:ADDR_WIDTH];
      end
   endgenerate

   assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && (read || write);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mdat_d     = mdat_q;
      is_write_d = is_write_q;
      err_d      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               addr_d     = MAR_in[ADDR_WIDTH-1:0];
               wdata_d    = MDR_in;
               cnt_d      = WAIT_INIT;
               // A simultaneous read+write request is resolved as a write.
               is_write_d = write;
               err_d      = read & write;
               state_d    = WAIT_EN ? S_WAIT : S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = is_write_q ? S_DONE : S_CAPTURE;
         end
         S_CAPTURE: begin
            mdat_d  = ram_rdata;
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mdat_q     <= '0;
         is_write_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mdat_q     <= mdat_d;
         is_write_q <= is_write_d;
         err_q      <= err_d;
      end
   end

   // Outputs are decoded from registered state so strobes are glitch-free single-cycle pulses.
   assign busy      = (state_q == S_WAIT) || (state_q == S_ISSUE) || (state_q == S_CAPTURE);
   assign mem_done  = (state_q == S_DONE);
   assign ram_re    = (state_q == S_ISSUE) && !is_write_q;
   assign ram_we    = (state_q == S_ISSUE) && is_write_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign Mdatain   = mdat_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: a cycle table for the default W=2 unit,
// plus hand sequences for W=0, mid-transaction clear and back-to-back requests.
module tb_mem_interface;

   logic        clk = 1'b0;
   logic        clr, rd, wr;
   logic [31:0] mar, mdr;

   logic [31:0] mdat, wdata, rdata;
   logic        done, busy, err, re, we;
   logic [8:0]  addr;

   logic [31:0] z_mdat, z_wdata, z_rdata;
   logic        z_done, z_busy, z_err, z_re, z_we;
   logic [8:0]  z_addr;

   logic [31:0] ram   [512];
   logic [31:0] z_ram [512];

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   mem_interface #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut (
      .clock(clk), .clear(clr), .read(rd), .write(wr), .MAR_in(mar), .MDR_in(mdr),
      .Mdatain(mdat), .mem_done(done), .busy(busy), .err(err),
      .ram_addr(addr), .ram_wdata(wdata), .ram_re(re), .ram_we(we), .ram_rdata(rdata)
   );

   mem_interface #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
      .clock(clk), .clear(clr), .read(rd), .write(wr), .MAR_in(mar), .MDR_in(mdr),
      .Mdatain(z_mdat), .mem_done(z_done), .busy(z_busy), .err(z_err),
      .ram_addr(z_addr), .ram_wdata(z_wdata), .ram_re(z_re), .ram_we(z_we), .ram_rdata(z_rdata)
   );

   // Synchronous single-port RAM models: read data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (we) ram[addr] <= wdata;
      if (re) rdata <= ram[addr];
      if (z_we) z_ram[z_addr] <= z_wdata;
      if (z_re) z_rdata <= z_ram[z_addr];
   end

   typedef struct {
      logic        clr, rd, wr;
      logic [31:0] mar, mdr;
      logic [4:0]  flags;   // {busy, mem_done, ram_we, ram_re, err}
      logic [8:0]  addr;
      logic [31:0] wdata, mdat;
   } vec_t;

   vec_t tbl [24];

   function automatic vec_t mk(input logic c, input logic r, input logic w,
                               input logic [31:0] ma, input logic [31:0] md,
                               input logic [4:0] fl, input logic [8:0] a,
                               input logic [31:0] wd, input logic [31:0] dm);
      vec_t v;
      v.clr = c; v.rd = r; v.wr = w; v.mar = ma; v.mdr = md;
      v.flags = fl; v.addr = a; v.wdata = wd; v.mdat = dm;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   // One clock cycle: drive inputs just after the edge, leave the caller at the falling edge.
   task automatic cyc(input logic c, input logic r, input logic w,
                      input logic [31:0] ma, input logic [31:0] md);
      @(posedge clk);
      #1;
      clr = c; rd = r; wr = w; mar = ma; mdr = md;
      @(negedge clk);
   endtask

   logic [15:0] done_mask, re_mask, we_mask;

   initial begin
      clr = 1'b1; rd = 1'b0; wr = 1'b0; mar = '0; mdr = '0;
      tbl[0]  = mk(0,0,0, 32'h0,         32'h0,         5'b00000, 9'h000, 32'h0,         32'h0);
      tbl[1]  = mk(0,0,1, 32'h1F4,       32'hDEADBEEF,  5'b00000, 9'h000, 32'h0,         32'h0);
      tbl[2]  = mk(0,0,0, 32'h0,         32'h0,         5'b10000, 9'h1F4, 32'hDEADBEEF,  32'h0);
      tbl[3]  = mk(0,0,0, 32'h0,         32'h0,         5'b10000, 9'h1F4, 32'hDEADBEEF,  32'h0);
      tbl[4]  = mk(0,0,0, 32'h0,         32'h0,         5'b10100, 9'h1F4, 32'hDEADBEEF,  32'h0);
      tbl[5]  = mk(0,0,0, 32'h0,         32'h0,         5'b01000, 9'h1F4, 32'hDEADBEEF,  32'h0);
      tbl[6]  = mk(0,0,0, 32'h0,         32'h0,         5'b00000, 9'h1F4, 32'hDEADBEEF,  32'h0);
      tbl[7]  = mk(0,1,0, 32'h1F4,       32'h0,         5'b00000, 9'h1F4, 32'hDEADBEEF,  32'h0);
      tbl[8]  = mk(0,0,0, 32'h0,         32'h0,         5'b10000, 9'h1F4, 32'h0,         32'h0);
      tbl[9]  = mk(0,0,0, 32'h0,         32'h0,         5'b10000, 9'h1F4, 32'h0,         32'h0);
      tbl[10] = mk(0,0,0, 32'h0,         32'h0,         5'b10010, 9'h1F4, 32'h0,         32'h0);
      tbl[11] = mk(0,0,0, 32'h0,         32'h0,         5'b10000, 9'h1F4, 32'h0,         32'h0);
      tbl[12] = mk(0,0,0, 32'h0,         32'h0,         5'b01000, 9'h1F4, 32'h0,         32'hDEADBEEF);
      tbl[13] = mk(0,0,1, 32'h010,       32'h12345678,  5'b00000, 9'h1F4, 32'h0,         32'hDEADBEEF);
      tbl[14] = mk(0,0,0, 32'h0,         32'h0,         5'b10000, 9'h010, 32'h12345678,  32'hDEADBEEF);
      tbl[15] = mk(0,0,0, 32'h0,         32'h0,         5'b10000, 9'h010, 32'h12345678,  32'hDEADBEEF);
      tbl[16] = mk(0,0,0, 32'h0,         32'h0,         5'b10100, 9'h010, 32'h12345678,  32'hDEADBEEF);
      tbl[17] = mk(0,0,0, 32'h0,         32'h0,         5'b01000, 9'h010, 32'h12345678,  32'hDEADBEEF);
      tbl[18] = mk(0,1,1, 32'h020,       32'hCAFEF00D,  5'b00000, 9'h010, 32'h12345678,  32'hDEADBEEF);
      tbl[19] = mk(0,0,0, 32'h0,         32'h0,         5'b10001, 9'h020, 32'hCAFEF00D,  32'hDEADBEEF);
      tbl[20] = mk(0,0,0, 32'h0,         32'h0,         5'b10000, 9'h020, 32'hCAFEF00D,  32'hDEADBEEF);
      tbl[21] = mk(0,0,0, 32'h0,         32'h0,         5'b10100, 9'h020, 32'hCAFEF00D,  32'hDEADBEEF);
      tbl[22] = mk(0,0,0, 32'h0,         32'h0,         5'b01000, 9'h020, 32'hCAFEF00D,  32'hDEADBEEF);
      tbl[23] = mk(0,0,0, 32'h0,         32'h0,         5'b00000, 9'h020, 32'hCAFEF00D,  32'hDEADBEEF);

      repeat (3) @(posedge clk);

      // W=2 write, read-back, plain write and read+write collision, cycle by cycle.
      for (int i = 0; i < 24; i++) begin
         cyc(tbl[i].clr, tbl[i].rd, tbl[i].wr, tbl[i].mar, tbl[i].mdr);
         $display("row %0d: flags=%b addr=%h wdata=%h Mdatain=%h",
                  i, {busy, done, we, re, err}, addr, wdata, mdat);
         chk($sformatf("row%0d_flags", i), 32'({busy, done, we, re, err}), 32'(tbl[i].flags));
         chk($sformatf("row%0d_addr", i),  32'(addr), 32'(tbl[i].addr));
         chk($sformatf("row%0d_wdata", i), wdata, tbl[i].wdata);
         chk($sformatf("row%0d_mdat", i),  mdat, tbl[i].mdat);
      end

      // W=0 unit: upper MAR bits dropped, strobe right after acceptance.
      cyc(0,0,1, 32'hFFFF_FE05, 32'hA5A5_0005);
      cyc(0,0,0, 32'h0, 32'h0);
      chk("w0_wr_issue", 32'({z_busy, z_we, z_re}), 32'(3'b110));
      chk("w0_wr_addr", 32'(z_addr), 32'h005);
      cyc(0,0,0, 32'h0, 32'h0);
      chk("w0_wr_done", 32'({z_done, z_busy, z_we}), 32'(3'b100));
      cyc(0,1,0, 32'hFFFF_FE05, 32'h0);
      cyc(0,0,0, 32'h0, 32'h0);
      chk("w0_rd_issue", 32'({z_re, z_we, z_addr}), 32'({2'b10, 9'h005}));
      cyc(0,0,0, 32'h0, 32'h0);
      chk("w0_rd_capture", 32'({z_busy, z_done}), 32'(2'b10));
      cyc(0,0,0, 32'h0, 32'h0);
      chk("w0_rd_done", 32'(z_done), 32'h1);
      chk("w0_rd_data", z_mdat, 32'hA5A5_0005);
      $display("w0 sequence: addr=%h Mdatain=%h", z_addr, z_mdat);
      repeat (3) cyc(0,0,0, 32'h0, 32'h0);

      // Clear during WAIT of a W=2 write; a request held alongside clear is ignored.
      cyc(0,0,1, 32'h033, 32'h55AA_55AA);
      cyc(0,0,0, 32'h0, 32'h0);
      chk("clr_busy_before", 32'(busy), 32'h1);
      cyc(1,0,1, 32'h044, 32'h1111_1111);
      cyc(0,0,0, 32'h0, 32'h0);
      chk("clr_outputs", 32'({busy, done, we, re, err}), 32'h0);
      chk("clr_addr", 32'(addr), 32'h0);
      chk("clr_wdata", wdata, 32'h0);
      chk("clr_mdat", mdat, 32'h0);
      we_mask = '0; done_mask = '0;
      for (int c = 0; c < 4; c++) begin
         cyc(0,0,0, 32'h0, 32'h0);
         we_mask[c] = we; done_mask[c] = done;
      end
      chk("clr_no_strobe", 32'(we_mask), 32'h0);
      chk("clr_no_done", 32'(done_mask), 32'h0);
      $display("clear sequence: we_mask=%b done_mask=%b", we_mask[3:0], done_mask[3:0]);

      // Requests toggled while busy are ignored; the read completes at T+5.
      re_mask = '0; we_mask = '0; done_mask = '0;
      for (int c = 0; c < 7; c++) begin
         case (c)
            0:       cyc(0,1,0, 32'h1F4, 32'h0);
            1:       cyc(0,0,1, 32'h0AA, 32'h7777_7777);
            2:       cyc(0,1,0, 32'h0AA, 32'h0);
            3:       cyc(0,1,1, 32'h0AA, 32'h7777_7777);
            4:       cyc(0,0,1, 32'h0AA, 32'h7777_7777);
            default: cyc(0,0,0, 32'h0, 32'h0);
         endcase
         re_mask[c] = re; we_mask[c] = we; done_mask[c] = done;
         if (c == 3) chk("ign_issue_addr", 32'(addr), 32'h1F4);
      end
      chk("ign_re", 32'(re_mask), 32'h0008);
      chk("ign_we", 32'(we_mask), 32'h0);
      chk("ign_done", 32'(done_mask), 32'h0020);
      chk("ign_mdat", mdat, 32'hDEADBEEF);
      $display("ignored-request sequence: re=%b done=%b", re_mask[6:0], done_mask[6:0]);

      // Read held high: one completion every W+3 = 5 cycles.
      re_mask = '0; done_mask = '0;
      for (int c = 0; c < 16; c++) begin
         cyc(0,1,0, 32'h1F4, 32'h0);
         re_mask[c] = re; done_mask[c] = done;
      end
      chk("b2b_done", 32'(done_mask), 32'h8420);
      chk("b2b_re", 32'(re_mask), 32'h2108);
      chk("b2b_mdat", mdat, 32'hDEADBEEF);
      $display("back-to-back reads: re=%b done=%b", re_mask, done_mask);
      repeat (8) cyc(0,0,0, 32'h0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
